// File: rtl/arb_pkg.sv
// Shared state encodings, policy constants and sizing helper for the request arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Hold counter width; a single-cycle hold limit still needs one bit to compare against.
    function automatic int cnt_width(input int hold_max);
        return (hold_max > 1) ? $clog2(hold_max) : 1;
    endfunction

endpackage

// File: rtl/req_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface req_arbiter_if #(
    parameter int IDX_W = 2
);
    localparam int N = 1 << IDX_W;

    logic             en;
    logic             mode;
    logic [N-1:0]     req;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;

    modport master (
        output en,
        output mode,
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid
    );

    modport slave (
        input  en,
        input  mode,
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid
    );

endinterface

// File: rtl/rr_prio_pick.sv
// Combinational downward priority search with wrap-around: rotate, pick first, unrotate.
module rr_prio_pick
    import arb_pkg::*;
#(
    parameter int IDX_W = 2
) (
    input  logic [(1<<IDX_W)-1:0] req_i,
    input  logic [IDX_W-1:0]      start_i,
    input  logic                  mode_i,
    output logic [IDX_W-1:0]      idx_o,
    output logic                  valid_o
);
    localparam int N = 1 << IDX_W;

    logic [IDX_W-1:0] base;
    logic [N-1:0]     rot;
    logic [IDX_W-1:0] off;

    // Fixed priority is simply a downward search that always starts at the top index.
    always_comb begin
        base = (mode_i == MODE_RR) ? start_i : IDX_W'(N - 1);
    end

    // rot[k] is the request k positions below base, wrapping modulo N.
    always_comb begin
        rot = '0;
        for (int k = 0; k < N; k++) begin
            rot[k] = req_i[base - IDX_W'(k)];
        end
    end

    always_comb begin
        off     = '0;
        valid_o = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off     = IDX_W'(k);
                valid_o = 1'b1;
            end
        end
    end

    assign idx_o = base - off;

endmodule

// File: rtl/req_arbiter.sv
// Two-state arbiter with fixed or round-robin policy, bounded hold time and registered one-hot grant.
module req_arbiter
    import arb_pkg::*;
#(
    parameter int IDX_W    = 2,
    parameter int HOLD_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    req_arbiter_if.slave  bus
);
    localparam int                N        = 1 << IDX_W;
    localparam int                CNT_W    = cnt_width(HOLD_MAX);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(HOLD_MAX - 1);

    arb_state_e       state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] last_q, last_d;

    logic [IDX_W-1:0] start_idx;
    logic [IDX_W-1:0] win_idx;
    logic             win_valid;
    logic             drop_grant;

    // The last winner gets lowest priority, so the search begins just below it.
    assign start_idx = last_q - IDX_W'(1);

    rr_prio_pick #(
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i   (bus.req),
        .start_i (start_idx),
        .mode_i  (bus.mode),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    assign drop_grant = !bus.req[idx_q] || !bus.en || (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (bus.en && win_valid) begin
                    state_d = GRANT;
                    gnt_d   = N'(1) << win_idx;
                    idx_d   = win_idx;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    last_d  = win_idx;
                end
            end
            GRANT: begin
                // Leaving GRANT always lands in IDLE, which guarantees the one-cycle gap.
                if (drop_grant) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    idx_d   = '0;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                idx_d   = '0;
                valid_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = valid_q;

endmodule

// File: tb/tb_req_arbiter.sv
// Scoreboard bench for req_arbiter: a behavioural model predicts every cycle and every grant event.
module tb_req_arbiter;
    import arb_pkg::*;

    localparam int IDX_W    = 2;
    localparam int N        = 1 << IDX_W;
    localparam int HOLD_MAX = 8;

    typedef struct {
        logic [N-1:0]     gnt;
        logic [IDX_W-1:0] idx;
        logic             valid;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    req_arbiter_if #(.IDX_W(IDX_W)) bus ();

    req_arbiter #(
        .IDX_W    (IDX_W),
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   testsRun    = 0;
    int   testsFailed = 0;
    exp_t cycleQ[$];
    int   grantQ[$];

    // Model state: holder = -1 means nobody owns the resource.
    int   mHolder = -1;
    int   mCycles = 0;
    int   mLast   = 0;

    function automatic int pickWinner(input logic [N-1:0] r, input logic m, input int last);
        int first;
        int i;
        first = (m == MODE_RR) ? ((last + N - 1) % N) : (N - 1);
        for (int k = 0; k < N; k++) begin
            i = (first - k + N) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    // Reference model: advances once per rising edge and queues what the outputs must show after it.
    always @(posedge clk) begin
        exp_t e;
        int   w;
        if (rst) begin
            mHolder = -1;
            mCycles = 0;
            mLast   = 0;
        end else if (mHolder < 0) begin
            w = pickWinner(bus.req, bus.mode, mLast);
            if (bus.en && w >= 0) begin
                mHolder = w;
                mCycles = 1;
                mLast   = w;
                grantQ.push_back(w);
            end
        end else begin
            if (!bus.req[mHolder] || !bus.en || mCycles >= HOLD_MAX) begin
                mHolder = -1;
            end else begin
                mCycles = mCycles + 1;
            end
        end
        e.valid = (mHolder >= 0);
        e.idx   = e.valid ? IDX_W'(mHolder) : '0;
        e.gnt   = e.valid ? (N'(1) << mHolder) : '0;
        cycleQ.push_back(e);
    end

    // Monitor: compares every cycle's outputs and every new grant against the queued predictions.
    logic prevValid = 1'b0;
    always @(posedge clk) begin
        exp_t e;
        int   g;
        #1;
        testsRun++;
        if (cycleQ.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL cycle_out t=%0t no prediction queued", $time);
        end else begin
            e = cycleQ.pop_front();
            if (bus.gnt !== e.gnt || bus.gnt_idx !== e.idx || bus.gnt_valid !== e.valid) begin
                testsFailed++;
                $display("[TB] FAIL cycle_out t=%0t got gnt=%b idx=%0d valid=%b want gnt=%b idx=%0d valid=%b",
                         $time, bus.gnt, bus.gnt_idx, bus.gnt_valid, e.gnt, e.idx, e.valid);
            end
        end
        if (bus.gnt_valid === 1'b1 && prevValid !== 1'b1) begin
            testsRun++;
            if (grantQ.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL grant_event t=%0t got idx=%0d want no grant", $time, bus.gnt_idx);
            end else begin
                g = grantQ.pop_front();
                if (int'(bus.gnt_idx) != g) begin
                    testsFailed++;
                    $display("[TB] FAIL grant_event t=%0t got idx=%0d want idx=%0d", $time, bus.gnt_idx, g);
                end
            end
        end
        prevValid = bus.gnt_valid;
    end

    task automatic applyStimulus(input logic r, input logic e, input logic m, input logic [N-1:0] rq);
        @(negedge clk);
        rst      = r;
        bus.en   = e;
        bus.mode = m;
        bus.req  = rq;
    endtask

    task automatic checkOutput(input string name, input logic [N-1:0] eg,
                               input logic [IDX_W-1:0] ei, input logic ev);
        testsRun++;
        if (bus.gnt !== eg || bus.gnt_idx !== ei || bus.gnt_valid !== ev) begin
            testsFailed++;
            $display("[TB] FAIL %s got gnt=%b idx=%0d valid=%b want gnt=%b idx=%0d valid=%b",
                     name, bus.gnt, bus.gnt_idx, bus.gnt_valid, eg, ei, ev);
        end
    endtask

    task automatic checkOrder(input string name, input int got[$], input int want[$]);
        for (int i = 0; i < want.size(); i++) begin
            testsRun++;
            if (i >= got.size()) begin
                testsFailed++;
                $display("[TB] FAIL %s[%0d] got none want %0d", name, i, want[i]);
            end else if (got[i] != want[i]) begin
                testsFailed++;
                $display("[TB] FAIL %s[%0d] got %0d want %0d", name, i, got[i], want[i]);
            end
        end
    endtask

    initial begin
        int   order[$];
        int   held;
        logic prev;
        bus.en   = 1'b0;
        bus.mode = MODE_FIXED;
        bus.req  = '0;

        // Reset then a fixed-priority pick between requesters 1 and 2.
        applyStimulus(1'b1, 1'b0, MODE_FIXED, 4'b0000);
        applyStimulus(1'b0, 1'b1, MODE_FIXED, 4'b0110);
        checkOutput("reset_state", 4'b0000, 2'd0, 1'b0);
        @(negedge clk);
        checkOutput("fixed_0110", 4'b0100, 2'd2, 1'b1);

        // Round-robin rotation with each holder dropping after two grant cycles.
        applyStimulus(1'b1, 1'b0, MODE_RR, 4'b0000);
        applyStimulus(1'b0, 1'b1, MODE_RR, 4'b1111);
        order.delete();
        held = 0;
        prev = 1'b0;
        for (int c = 0; c < 40 && order.size() < 5; c++) begin
            @(negedge clk);
            if (bus.gnt_valid) begin
                if (!prev) order.push_back(int'(bus.gnt_idx));
                held++;
                if (held == 2) bus.req[bus.gnt_idx] = 1'b0;
            end else begin
                held    = 0;
                bus.req = 4'b1111;
            end
            prev = bus.gnt_valid;
        end
        checkOrder("rr_order", order, '{3, 2, 1, 0, 3});

        // Single holder hits the hold limit, idles one cycle, then wins again.
        applyStimulus(1'b1, 1'b0, MODE_FIXED, 4'b0000);
        applyStimulus(1'b0, 1'b1, MODE_FIXED, 4'b0010);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 9) checkOutput($sformatf("timeout_c%0d", c), 4'b0000, 2'd0, 1'b0);
            else        checkOutput($sformatf("timeout_c%0d", c), 4'b0010, 2'd1, 1'b1);
        end

        // Two persistent requesters alternate on timeout in round-robin.
        applyStimulus(1'b1, 1'b0, MODE_RR, 4'b0000);
        applyStimulus(1'b0, 1'b1, MODE_RR, 4'b1001);
        order.delete();
        prev = 1'b0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (bus.gnt_valid && !prev) order.push_back(int'(bus.gnt_idx));
            prev = bus.gnt_valid;
        end
        checkOrder("rr_timeout", order, '{3, 0, 3});

        // Enable drop revokes the grant and blocks arbitration until it returns.
        applyStimulus(1'b1, 1'b0, MODE_FIXED, 4'b0000);
        applyStimulus(1'b0, 1'b1, MODE_FIXED, 4'b1000);
        @(negedge clk);
        checkOutput("en_grant", 4'b1000, 2'd3, 1'b1);
        bus.en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput($sformatf("en_low_%0d", c), 4'b0000, 2'd0, 1'b0);
        end
        bus.en = 1'b1;
        @(negedge clk);
        checkOutput("en_regrant", 4'b1000, 2'd3, 1'b1);

        // Reset in the middle of a round-robin grant also forgets the last winner.
        applyStimulus(1'b1, 1'b0, MODE_RR, 4'b0000);
        applyStimulus(1'b0, 1'b1, MODE_RR, 4'b1111);
        @(negedge clk);
        checkOutput("rst_pre", 4'b1000, 2'd3, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_after", 4'b1000, 2'd3, 1'b1);

        // Randomised traffic: fast-changing requests first, then long holds to reach timeouts.
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            rst    = ($urandom_range(0, 199) == 0);
            bus.en = ($urandom_range(0, 11) != 0);
            if ($urandom_range(0, 3) == 0) bus.mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, (c < 1000) ? 2 : 19) == 0) bus.req = 4'($urandom);
        end

        applyStimulus(1'b0, 1'b0, MODE_FIXED, 4'b0000);
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
